// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD digit type, width and 9's-complement helper.
package bcd_pkg;
    localparam int DIGIT_W = 4;
    typedef logic [DIGIT_W-1:0] bcd_digit_t;
    function automatic bcd_digit_t bcd_nines(bcd_digit_t d);
        return bcd_digit_t'(DIGIT_W'(9) - d);
    endfunction
endpackage

// File: rtl/bcd_digit_add.sv
// bcd_digit_add: combinational single-digit BCD adder with invalid-digit flag.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] a_d,
    input  logic [DIGIT_W-1:0] b_d,
    input  logic               ci,
    output logic [DIGIT_W-1:0] digit,
    output logic               co,
    output logic               bad
);
    logic [DIGIT_W:0] w_s;
    assign w_s   = {1'b0, a_d} + {1'b0, b_d} + {{DIGIT_W{1'b0}}, ci};
    assign co    = w_s > (DIGIT_W+1)'(9);
    assign digit = co ? w_s[DIGIT_W-1:0] + DIGIT_W'(6) : w_s[DIGIT_W-1:0];
    assign bad   = (a_d > DIGIT_W'(9)) | (b_d > DIGIT_W'(9));
endmodule

// File: rtl/bcd_adder_pipe.sv
// bcd_adder_pipe: pipelined packed-BCD adder, one digit group per stage, valid/ready handshake.
// Define BCD_SUB_EN to add the sub port (a - b - cin via 9's complement).
module bcd_adder_pipe
    import bcd_pkg::*;
#(
    parameter int DIGITS           = 4,
    parameter int DIGITS_PER_STAGE = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DIGIT_W*DIGITS-1:0] a,
    input  logic [DIGIT_W*DIGITS-1:0] b,
    input  logic                      cin,
`ifdef BCD_SUB_EN
    input  logic                      sub,
`endif
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DIGIT_W*DIGITS-1:0] sum,
    output logic                      cout,
    output logic                      err
);
    localparam int S  = DIGITS / DIGITS_PER_STAGE;
    localparam int W  = DIGIT_W * DIGITS;
    localparam int GW = DIGIT_W * DIGITS_PER_STAGE;

    logic         w_adv, w_sub;
    logic [S:0]   r_v, r_c, r_s;
    logic [S:1]   r_e, w_co, w_bad;
    logic [W-1:0] w_bx;

`ifdef BCD_SUB_EN
    assign w_sub = sub;
`else
    assign w_sub = 1'b0;
`endif

    assign w_adv     = !r_v[S] || out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_v[S];
    assign sum       = g_st[S].r_sum;
    assign cout      = r_c[S] ^ r_s[S];
    assign err       = r_e[S];

    for (genvar i = 0; i < DIGITS; i++) begin : g_bx
        assign w_bx[DIGIT_W*i +: DIGIT_W] = w_sub ? bcd_nines(b[DIGIT_W*i +: DIGIT_W]) : b[DIGIT_W*i +: DIGIT_W];
    end

    // 9's complement maps digits >9 to digits >9, so bad flags on b stay exact when subtracting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v <= '0;
            r_c <= '0;
            r_s <= '0;
            r_e <= '0;
        end else if (w_adv) begin
            r_v    <= {r_v[S-1:0], in_valid};
            r_c    <= {w_co, w_sub ? !cin : cin};
            r_s    <= {r_s[S-1:0], w_sub};
            r_e[1] <= w_bad[1];
            for (int k = 2; k <= S; k++) r_e[k] <= r_e[k-1] | w_bad[k];
        end
    end

    // g_st[k]: r_a/r_b feed adder k (groups k-1 and up), r_sum holds groups 0..k-1 after it
    for (genvar k = 1; k <= S; k++) begin : g_st
        logic [W-(k-1)*GW-1:0]     r_a, r_b;
        logic [k*GW-1:0]           r_sum;
        logic [GW-1:0]             w_grp;
        logic [DIGITS_PER_STAGE:0] w_ch;
        logic [DIGITS_PER_STAGE-1:0] w_bd;
        assign w_ch[0]  = r_c[k-1];
        assign w_co[k]  = w_ch[DIGITS_PER_STAGE];
        assign w_bad[k] = |w_bd;
        for (genvar d = 0; d < DIGITS_PER_STAGE; d++) begin : g_dig
            bcd_digit_add u_dig (
                .a_d   (r_a[DIGIT_W*d +: DIGIT_W]),
                .b_d   (r_b[DIGIT_W*d +: DIGIT_W]),
                .ci    (w_ch[d]),
                .digit (w_grp[DIGIT_W*d +: DIGIT_W]),
                .co    (w_ch[d+1]),
                .bad   (w_bd[d])
            );
        end
        if (k == 1) begin : g_first
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_a   <= '0;
                    r_b   <= '0;
                    r_sum <= '0;
                end else if (w_adv) begin
                    r_a   <= a;
                    r_b   <= w_bx;
                    r_sum <= w_grp;
                end
            end
        end else begin : g_next
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_a   <= '0;
                    r_b   <= '0;
                    r_sum <= '0;
                end else if (w_adv) begin
                    r_a   <= g_st[k-1].r_a[W-(k-2)*GW-1:GW];
                    r_b   <= g_st[k-1].r_b[W-(k-2)*GW-1:GW];
                    r_sum <= {w_grp, g_st[k-1].r_sum};
                end
            end
        end
    end
endmodule

// File: tb/tb_bcd_adder_pipe.sv
// tb_bcd_adder_pipe: directed checks of bcd_adder_pipe (DIGITS=4, one digit per stage).
module tb_bcd_adder_pipe;
    logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1, cin = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic        in_ready, out_valid, cout, err;
    logic [15:0] sum;
`ifdef BCD_SUB_EN
    logic        sub = 1'b0;
`endif
    int          checks = 0, errors = 0;
    logic [15:0] va [8], vb [8];
    logic        vc [8];
    logic [16:0] exp_q [$];
    int          sent, got;

    always #5 clk = ~clk;

    bcd_adder_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef BCD_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .err       (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic int bcd2int(input logic [15:0] v);
        int r = 0;
        for (int i = 3; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [15:0] int2bcd(input int n);
        logic [15:0] r = '0;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(n % 10);
            n = n / 10;
        end
        return r;
    endfunction

    function automatic logic [16:0] model(input logic [15:0] x, input logic [15:0] y, input logic c);
        int s = bcd2int(x) + bcd2int(y) + int'(c);
        return {s >= 10000, int2bcd(s % 10000)};
    endfunction

    function automatic logic [15:0] rnd_bcd();
        logic [15:0] r;
        for (int i = 0; i < 4; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    task automatic send_single(input string tag, input logic [15:0] xa, input logic [15:0] xb, input logic xc,
                               input logic [15:0] es, input logic ec, input logic ee);
        a = xa; b = xb; cin = xc; in_valid = 1'b1; out_ready = 1'b1;
        step;
        in_valid = 1'b0;
        step; step; step;
        chk({tag, "_early"}, out_valid, 1'b0);
        step;
        chk({tag, "_valid"}, out_valid, 1'b1);
        chk({tag, "_sum"}, sum, es);
        chk({tag, "_cout"}, cout, ec);
        chk({tag, "_err"}, err, ee);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        #12;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_sum", sum, 16'h0000);
        chk("rst_cout", cout, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        step;
        rst_n = 1'b1;
        send_single("carry_all", 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        send_single("mixed", 16'h1234, 16'h5678, 1'b1, 16'h6913, 1'b0, 1'b0);
        send_single("bad_digit", 16'h00A0, 16'h0000, 1'b0, 16'h0100, 1'b0, 1'b1);
        send_single("cin_only", 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);
`ifdef BCD_SUB_EN
        sub = 1'b1;
        send_single("sub_borrow", 16'h0100, 16'h0001, 1'b0, 16'h0099, 1'b0, 1'b0);
        send_single("sub_wrap", 16'h0000, 16'h0001, 1'b0, 16'h9999, 1'b1, 1'b0);
        sub = 1'b0;
`endif
        step;
        for (int i = 0; i < 8; i++) begin
            va[i] = rnd_bcd();
            vb[i] = rnd_bcd();
            vc[i] = 1'($urandom_range(0, 1));
        end
        sent = 0;
        got = 0;
        for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
            out_ready = !(cyc >= 5 && cyc <= 7);
            in_valid = sent < 8;
            if (sent < 8) begin
                a = va[sent]; b = vb[sent]; cin = vc[sent];
            end
            #1;
            if (cyc >= 5 && cyc <= 7) chk("stall_in_ready", in_ready, 1'b0);
            if (out_valid) begin
                if (exp_q.size() == 0) chk("stream_spurious", out_valid, 1'b0);
                else begin
                    chk("stream_sum", sum, exp_q[0][15:0]);
                    chk("stream_cout", cout, exp_q[0][16]);
                    chk("stream_err", err, 1'b0);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        got++;
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(va[sent], vb[sent], vc[sent]));
                sent++;
            end
            step;
        end
        chk("stream_got", got, 8);
        chk("stream_sent", sent, 8);
        chk("stream_drained", out_valid, 1'b0);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a = va[i]; b = vb[i]; cin = vc[i]; in_valid = 1'b1;
            step;
        end
        in_valid = 1'b0;
        step; step;
        chk("pre_reset_valid", out_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_sum", sum, 16'h0000);
        step;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step;
            chk("post_reset_idle", out_valid, 1'b0);
        end
        send_single("post_reset", 16'h0505, 16'h0505, 1'b0, 16'h1010, 1'b0, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
